// File: rtl/game_pkg.sv
// Shared types and constants for the snakes-and-ladders turn controller:
// FSM state encoding, position width and the board-map source/destination table.
package game_pkg;

    localparam int unsigned POS_W = 7;
    localparam int unsigned MAP_N = 6;

    typedef enum logic [2:0] {
        StIdle,
        StReady,
        StRoll,
        StSample,
        StMove,
        StJump,
        StUpdate,
        StDone
    } game_state_e;

    // Entry i maps MAP_SRC[i] to MAP_DST[i]; ladders first, then snakes.
    localparam logic [MAP_N-1:0][POS_W-1:0] MAP_SRC = {
        7'd51, 7'd39, 7'd27, 7'd11, 7'd5, 7'd3
    };
    localparam logic [MAP_N-1:0][POS_W-1:0] MAP_DST = {
        7'd19, 7'd3, 7'd1, 7'd26, 7'd8, 7'd22
    };

    function automatic logic dice_ok(input logic [2:0] d);
        return (d != 3'd0) && (d != 3'd7);
    endfunction

endpackage

// File: rtl/board_map.sv
// Combinational board map: returns the square a piece ends on after any
// snake or ladder at the target square; unlisted squares pass through.
module board_map
    import game_pkg::*;
(
    input  logic [POS_W-1:0] target,
    output logic [POS_W-1:0] landed
);

    always_comb begin
        landed = target;
        for (int i = 0; i < int'(MAP_N); i++) begin
            if (target == MAP_SRC[i]) begin
                landed = MAP_DST[i];
            end
        end
    end

endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencer for a 2..4 player snakes-and-ladders game.
// Optional macro SL_EXTRA_TURN_EN: a captured 6 without a win keeps the same player.
module game_turn_controller
    import game_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned BOARD_MAX   = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        roll_btn,
    input  logic [2:0]  dice_value,
    output logic        dice_roll,
    output logic [1:0]  active_player,
    output logic [27:0] positions,
    output logic        busy,
    output logic        turn_done,
    output logic        winner_valid,
    output logic [1:0]  winner_id
);

    localparam logic [1:0]       LastPlayer = 2'(NUM_PLAYERS - 1);
    localparam logic [7:0]       BoardMaxW  = 8'(BOARD_MAX);
    localparam logic [POS_W-1:0] BoardMaxP  = POS_W'(BOARD_MAX);

    game_state_e             state_q, state_d;
    logic [3:0][POS_W-1:0]   pos_q, pos_d;
    logic [1:0]              active_q, active_d;
    logic [1:0]              winner_q, winner_d;
    logic [2:0]              dice_q, dice_d;
    logic [POS_W-1:0]        target_q, target_d;

    logic [POS_W-1:0]        cur_pos;
    logic [7:0]              sum;
    logic [POS_W-1:0]        landed;
    logic                    keep_turn;

    assign cur_pos = pos_q[active_q];
    assign sum     = {1'b0, cur_pos} + {5'b0, dice_q};

    board_map u_board_map (
        .target (target_q),
        .landed (landed)
    );

`ifdef SL_EXTRA_TURN_EN
    assign keep_turn = (dice_q == 3'd6);
`else
    assign keep_turn = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        active_d = active_q;
        winner_d = winner_q;
        dice_d   = dice_q;
        target_d = target_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StReady;
                    pos_d    = '0;
                    active_d = 2'd0;
                    winner_d = 2'd0;
                end
            end
            StReady: begin
                // start wins over roll_btn and restarts on a clean board
                if (start) begin
                    pos_d    = '0;
                    active_d = 2'd0;
                    winner_d = 2'd0;
                end else if (roll_btn) begin
                    state_d = StRoll;
                end
            end
            StRoll: begin
                state_d = StSample;
            end
            StSample: begin
                dice_d  = dice_value;
                state_d = dice_ok(dice_value) ? StMove : StRoll;
            end
            StMove: begin
                // exact landing: overshooting the last square leaves the piece in place
                target_d = (sum > BoardMaxW) ? cur_pos : sum[POS_W-1:0];
                state_d  = StJump;
            end
            StJump: begin
                pos_d[active_q] = landed;
                state_d         = StUpdate;
            end
            StUpdate: begin
                if (cur_pos == BoardMaxP) begin
                    winner_d = active_q;
                    state_d  = StDone;
                end else begin
                    if (!keep_turn) begin
                        active_d = (active_q == LastPlayer) ? 2'd0 : active_q + 2'd1;
                    end
                    state_d = StReady;
                end
            end
            StDone: begin
                if (start) begin
                    pos_d    = '0;
                    active_d = 2'd0;
                    winner_d = 2'd0;
                    state_d  = StReady;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            pos_q    <= '0;
            active_q <= 2'd0;
            winner_q <= 2'd0;
            dice_q   <= 3'd0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            active_q <= active_d;
            winner_q <= winner_d;
            dice_q   <= dice_d;
            target_q <= target_d;
        end
    end

    assign dice_roll     = (state_q == StRoll);
    assign turn_done     = (state_q == StUpdate);
    assign winner_valid  = (state_q == StDone);
    assign winner_id     = winner_q;
    assign active_player = active_q;
    assign busy          = !((state_q == StIdle) || (state_q == StReady) || (state_q == StDone));

    always_comb begin
        positions = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(NUM_PLAYERS)) begin
                positions[i*POS_W +: POS_W] = pos_q[i];
            end
        end
    end

endmodule

// File: tb/tb_game_turn_controller.sv
// Randomized scoreboard bench for game_turn_controller with a 3-player board.
module tb_game_turn_controller;

    localparam int NP   = 3;
    localparam int BMAX = 100;
`ifdef SL_EXTRA_TURN_EN
    localparam bit Extra = 1'b1;
`else
    localparam bit Extra = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        roll_btn = 1'b0;
    logic [2:0]  dice_value = 3'd0;
    logic        dice_roll;
    logic [1:0]  active_player;
    logic [27:0] positions;
    logic        busy;
    logic        turn_done;
    logic        winner_valid;
    logic [1:0]  winner_id;

    always #5 clk = ~clk;

    game_turn_controller #(
        .NUM_PLAYERS (NP),
        .BOARD_MAX   (BMAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .roll_btn      (roll_btn),
        .dice_value    (dice_value),
        .dice_roll     (dice_roll),
        .active_player (active_player),
        .positions     (positions),
        .busy          (busy),
        .turn_done     (turn_done),
        .winner_valid  (winner_valid),
        .winner_id     (winner_id)
    );

    typedef struct packed {
        logic [27:0] pos;
        logic [1:0]  player;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   feed[$];
    int   strobes = 0;
    int   td_count = 0;

    int   m_pos[4];
    int   m_active;
    bit   m_done;
    int   m_winner;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int board(input int t);
        case (t)
            3:  return 22;
            5:  return 8;
            11: return 26;
            27: return 1;
            39: return 3;
            51: return 19;
            default: return t;
        endcase
    endfunction

    function automatic logic [27:0] pack_pos();
        logic [27:0] v = '0;
        for (int i = 0; i < 4; i++) v[i*7 +: 7] = 7'(m_pos[i]);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_pos[i] = 0;
        m_active = 0;
        m_done   = 1'b0;
        m_winner = 0;
    endfunction

    function automatic void model_turn(input int d);
        int   p = m_active;
        int   t = m_pos[p] + d;
        exp_t e;
        if (t > BMAX) t = m_pos[p];
        t        = board(t);
        m_pos[p] = t;
        e.pos    = pack_pos();
        e.player = 2'(p);
        sb.push_back(e);
        if (t == BMAX) begin
            m_done   = 1'b1;
            m_winner = p;
        end else if (!(Extra && d == 6)) begin
            m_active = (p + 1) % NP;
        end
    endfunction

    // Dice block: answers every strobe with the next queued value.
    initial forever begin
        @(negedge clk);
        if (dice_roll) begin
            strobes++;
            if (feed.size() > 0) begin
                dice_value = 3'(feed.pop_front());
            end else begin
                dice_value = 3'd1;
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe expected none at %0t", $time);
            end
        end
    end

    // Scoreboard monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (turn_done) begin
            td_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_turn_done: got pulse expected none at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("sb_positions", 32'(positions), 32'(e.pos));
                check("sb_player", 32'(active_player), 32'(e.player));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_turn(input int d, input int bad);
        int before_td = td_count;
        int before_st = strobes;
        int cyc = 0;
        for (int i = 0; i < bad; i++) feed.push_back((i == 0) ? 0 : ($urandom_range(0, 1) ? 7 : 0));
        feed.push_back(d);
        model_turn(d);
        @(negedge clk);
        roll_btn = 1'b1;
        @(negedge clk);
        roll_btn = 1'b0;
        check("dice_roll_after_btn", 32'(dice_roll), 32'd1);
        while (busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("turn_cycles", 32'(cyc), 32'(5 + 2 * bad));
        check("turn_done_pulses", 32'(td_count - before_td), 32'd1);
        check("dice_strobes", 32'(strobes - before_st), 32'(bad + 1));
        check("active_after", 32'(active_player), 32'(m_active));
        check("winner_valid", 32'(winner_valid), 32'(m_done));
    endtask

    task automatic restart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset();
        check("restart_positions", 32'(positions), 32'd0);
        check("restart_active", 32'(active_player), 32'd0);
        check("restart_busy", 32'(busy), 32'd0);
        check("restart_winner_valid", 32'(winner_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_positions"}, 32'(positions), 32'd0);
        check({tag, "_active"}, 32'(active_player), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_dice_roll"}, 32'(dice_roll), 32'd0);
        check({tag, "_turn_done"}, 32'(turn_done), 32'd0);
        check({tag, "_winner_valid"}, 32'(winner_valid), 32'd0);
        check({tag, "_winner_id"}, 32'(winner_id), 32'd0);
    endtask

    initial begin
        int guard;
        int td_before;
        int st_before;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // roll_btn in IDLE does nothing
        @(negedge clk);
        roll_btn = 1'b1;
        @(negedge clk);
        roll_btn = 1'b0;
        check("idle_ignores_roll", 32'(busy), 32'd0);

        restart();
        do_turn(4, 0);
        check("first_move_p0", 32'(positions[6:0]), 32'd4);

        // start has priority over roll_btn in READY
        @(negedge clk);
        start    = 1'b1;
        roll_btn = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        roll_btn = 1'b0;
        model_reset();
        check("start_prio_busy", 32'(busy), 32'd0);
        check("start_prio_positions", 32'(positions), 32'd0);

        // ladder for P0, then walk P1 to 24 and hit the 27 snake
        do_turn(3, 0);
        check("ladder_p0", 32'(positions[6:0]), 32'd22);
        guard = 0;
        while (m_pos[1] != 24 && guard < 60) begin
            do_turn((m_active == 1) ? 6 : 1, 0);
            guard++;
        end
        guard = 0;
        while (m_active != 1 && guard < 10) begin
            do_turn(1, 0);
            guard++;
        end
        do_turn(3, 0);
        check("snake_p1", 32'(positions[13:7]), 32'd1);

        // invalid dice values force re-strobes
        restart();
        do_turn(2, 1);
        check("reroll_p0", 32'(positions[6:0]), 32'd2);
        do_turn(5, 2);

        // reset mid-turn: no write, no pulse
        feed.push_back(4);
        td_before = td_count;
        @(negedge clk);
        roll_btn = 1'b1;
        @(negedge clk);
        roll_btn = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midturn_reset");
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        check("midturn_no_pulse", 32'(td_count - td_before), 32'd0);
        restart();

        // drive P0 to 97, overshoot, then exact win
        guard = 0;
        while (m_pos[0] < 96 && guard < 80) begin
            do_turn((m_active == 0) ? 6 : 1, 0);
            guard++;
        end
        guard = 0;
        while (m_pos[0] != 97 && guard < 10) begin
            do_turn(1, 0);
            guard++;
        end
        guard = 0;
        while (m_active != 0 && guard < 10) begin
            do_turn(1, 0);
            guard++;
        end
        do_turn(5, 0);
        check("overshoot_stay", 32'(positions[6:0]), 32'd97);
        check("overshoot_pass", 32'(active_player), 32'd1);
        guard = 0;
        while (m_active != 0 && guard < 10) begin
            do_turn(1, 0);
            guard++;
        end
        do_turn(3, 0);
        check("win_pos", 32'(positions[6:0]), 32'd100);
        check("win_valid", 32'(winner_valid), 32'd1);
        check("win_id", 32'(winner_id), 32'd0);
        st_before = strobes;
        @(negedge clk);
        roll_btn = 1'b1;
        @(negedge clk);
        roll_btn = 1'b0;
        repeat (3) @(negedge clk);
        check("done_ignores_roll", 32'(strobes - st_before), 32'd0);
        check("done_holds_valid", 32'(winner_valid), 32'd1);
        check("done_holds_positions", 32'(positions), 32'(pack_pos()));
        check("done_busy", 32'(busy), 32'd0);

        // randomized play
        restart();
        for (int n = 0; n < 45; n++) begin
            if (m_done) restart();
            do_turn(int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        check("slot3_zero", 32'(positions[27:21]), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
